// File: rtl/dsp_madd_pkg.sv
// Purpose : shared widths, constant and vector types for the shifted-a multiply-add stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package dsp_madd_pkg;

    localparam int A_W = 20;
    localparam int B_W = 18;
    localparam int SH_W = 6;
    localparam int Z_W = 38;

    localparam int unsigned MULT_CONST_DEF = 4096;

    // Widest constant the multiplier has to carry (MULT_CONST <= 2^20).
    localparam int MC_W = 21;

    typedef logic [A_W-1:0]  a_t;
    typedef logic [B_W-1:0]  b_t;
    typedef logic [SH_W-1:0] sh_t;
    typedef logic [Z_W-1:0]  z_t;

endpackage : dsp_madd_pkg

// File: rtl/dsp_barrel_shl.sv
// Purpose : logarithmic zero-filling left shifter; shifts of W or more give 0.
// Latency : combinational.
// Backpressure: none (pure function of inputs).
// Ports   : data_i [W-1:0] value to shift, shamt_i [SW-1:0] shift amount,
//           data_o [W-1:0] shifted result.
module dsp_barrel_shl #(
    parameter int W  = 38,
    parameter int SW = 6
) (
    input  logic [W-1:0]  data_i,
    input  logic [SW-1:0] shamt_i,
    output logic [W-1:0]  data_o
);

    logic [W-1:0] stg [0:SW];

    assign stg[0] = data_i;

    // Stage k shifts by 2^k when bit k of the amount is set. A stage whose
    // step already reaches W flushes to zero, which also covers every
    // out-of-range total shift.
    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam longint STEP = longint'(1) << k;
        if (STEP >= W) begin : g_flush
            assign stg[k+1] = shamt_i[k] ? '0 : stg[k];
        end else begin : g_shift
            assign stg[k+1] = shamt_i[k] ? (stg[k] << STEP) : stg[k];
        end
    end

    assign data_o = stg[SW];

endmodule : dsp_barrel_shl

// File: rtl/dsp_shifted_a_mult_add.sv
// Purpose : z = ((a << acc_fir) + b * MULT_CONST) mod 2^Z_WIDTH, one registered output.
// Latency : 1 cycle; 2 cycles when DSP_INPUT_REG_EN is defined (inputs registered first).
// Backpressure: none; en=0 freezes every register, a new input set is taken each enabled cycle.
// Ports   : clk, rst_n (async active-low), en (clock enable), a [A_WIDTH], b [B_WIDTH],
//           acc_fir [SHIFT_WIDTH] shift amount, z_out [Z_WIDTH] registered result.
// Build option: DSP_INPUT_REG_EN adds a reset-to-zero, en-gated register on a, b and acc_fir.
module dsp_shifted_a_mult_add
    import dsp_madd_pkg::*;
#(
    parameter int          A_WIDTH     = A_W,
    parameter int          B_WIDTH     = B_W,
    parameter int          SHIFT_WIDTH = SH_W,
    parameter int          Z_WIDTH     = Z_W,
    parameter int unsigned MULT_CONST  = MULT_CONST_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [A_WIDTH-1:0]     a,
    input  logic [B_WIDTH-1:0]     b,
    input  logic [SHIFT_WIDTH-1:0] acc_fir,
    output logic [Z_WIDTH-1:0]     z_out
);

    // Full product width, then widened to at least Z_WIDTH so truncation
    // and zero-extension are both plain slices.
    localparam int P_W   = B_WIDTH + MC_W;
    localparam int EXT_W = (P_W > Z_WIDTH) ? P_W : Z_WIDTH;
    localparam logic [EXT_W-1:0] MC_EXT = EXT_W'(MULT_CONST);

    logic [A_WIDTH-1:0]     a_s;
    logic [B_WIDTH-1:0]     b_s;
    logic [SHIFT_WIDTH-1:0] sh_s;

`ifdef DSP_INPUT_REG_EN
    logic [A_WIDTH-1:0]     a_q;
    logic [B_WIDTH-1:0]     b_q;
    logic [SHIFT_WIDTH-1:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            sh_q <= '0;
        end else if (en) begin
            a_q  <= a;
            b_q  <= b;
            sh_q <= acc_fir;
        end
    end

    assign a_s  = a_q;
    assign b_s  = b_q;
    assign sh_s = sh_q;
`else
    assign a_s  = a;
    assign b_s  = b;
    assign sh_s = acc_fir;
`endif

    // Shifted-a term: a zero-extended to the result width before shifting,
    // so anything pushed past the MSB is simply lost.
    logic [Z_WIDTH-1:0] a_ext;
    logic [Z_WIDTH-1:0] sh_term;

    assign a_ext = {{(Z_WIDTH-A_WIDTH){1'b0}}, a_s};

    dsp_barrel_shl #(
        .W  (Z_WIDTH),
        .SW (SHIFT_WIDTH)
    ) u_shl (
        .data_i  (a_ext),
        .shamt_i (sh_s),
        .data_o  (sh_term)
    );

    // Constant product, unsigned, computed wide then truncated.
    logic [EXT_W-1:0]   b_ext;
    logic [EXT_W-1:0]   p_full;
    logic [Z_WIDTH-1:0] p_term;

    assign b_ext  = {{(EXT_W-B_WIDTH){1'b0}}, b_s};
    assign p_full = b_ext * MC_EXT;
    assign p_term = p_full[Z_WIDTH-1:0];

    // Sum wraps: carry out of the MSB is dropped by the result width.
    logic [Z_WIDTH-1:0] z_d;
    logic [Z_WIDTH-1:0] z_q;

    assign z_d = sh_term + p_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= '0;
        end else if (en) begin
            z_q <= z_d;
        end
    end

    assign z_out = z_q;

endmodule : dsp_shifted_a_mult_add

// File: tb/tb_dsp_shifted_a_mult_add.sv
module tb_dsp_shifted_a_mult_add;
    import dsp_madd_pkg::*;

`ifdef DSP_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam longint unsigned ZMASK = (longint'(1) << Z_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    a_t   a;
    b_t   b;
    sh_t  acc_fir;
    z_t   z_out;

    int n_assert = 0;
    int n_fail   = 0;

    longint unsigned exp_arr [0:1023];

    dsp_shifted_a_mult_add dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a),
        .b       (b),
        .acc_fir (acc_fir),
        .z_out   (z_out)
    );

    always #5 clk = ~clk;

    // Reference: independent 64-bit arithmetic model.
    function automatic longint unsigned model(input longint unsigned av,
                                              input longint unsigned bv,
                                              input int unsigned     sv);
        longint unsigned sh;
        sh = (sv >= Z_W) ? 64'd0 : ((av << sv) & ZMASK);
        return (sh + bv * 64'd4096) & ZMASK;
    endfunction

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        longint unsigned av, bv, sv;

        // Reset held with random inputs.
        rst_n = 1'b0; en = 1'b1;
        a = a_t'($urandom); b = b_t'($urandom); acc_fir = sh_t'($urandom);
        #2;
        check("reset_async", 64'(z_out), 64'd0);
        tick(3);
        check("reset_hold", 64'(z_out), 64'd0);

        // Release and first vector.
        @(negedge clk); rst_n = 1'b1;
        a = 255; b = 1; acc_fir = 1;
        tick(LAT);
        check("first_vec", 64'(z_out), 64'd4606);

        // Out-of-range shift.
        a = 20'hFFFFF; b = 18'h3FFFF; acc_fir = 63;
        tick(LAT);
        check("shift63", 64'(z_out), 64'd1073737728);

        a = 20'hFFFFF; b = 18'h3FFFF; acc_fir = 38;
        tick(LAT);
        check("shift38", 64'(z_out), 64'd1073737728);

        // Shift truncation.
        a = 20'hFFFFF; b = 0; acc_fir = 19;
        tick(LAT);
        check("shift19_trunc", 64'(z_out), 64'd274877382656);

        acc_fir = 18;
        tick(LAT);
        check("shift18", 64'(z_out), 64'd274877644800);

        // Largest in-range shift: only bit 0 of a survives into bit 37.
        a = 20'h00001; b = 0; acc_fir = 37;
        tick(LAT);
        check("shift37", 64'(z_out), 64'd137438953472);

        // Sum wraps exactly to zero.
        a = 20'hFFFFF; acc_fir = 18; b = 18'h40;
        tick(LAT);
        check("wrap_zero", 64'(z_out), 64'd0);

        // Wrap with a remainder.
        b = 18'h41;
        tick(LAT);
        check("wrap_rem", 64'(z_out), 64'd4096);

        // Enable hold.
        a = 255; b = 1; acc_fir = 1;
        tick(LAT);
        check("hold_load", 64'(z_out), 64'd4606);
        en = 1'b0;
        a = 20'h12345; b = 18'h2AAAA; acc_fir = 7;
        tick(1);
        check("hold_c1", 64'(z_out), 64'd4606);
        tick(2);
        check("hold_c3", 64'(z_out), 64'd4606);
        en = 1'b1;
        tick(LAT);
        check("hold_release", 64'(z_out), model(64'h12345, 64'h2AAAA, 7));

        // Mid-stream asynchronous reset.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_async", 64'(z_out), 64'd0);
        tick(1);
        check("midreset_hold", 64'(z_out), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        a = 3; b = 2; acc_fir = 4;
        tick(LAT);
        check("post_reset", 64'(z_out), 64'd8240);

        // Random regression, one new vector per enabled cycle.
        for (int i = 0; i < 1000 + LAT - 1; i++) begin
            av = 64'($urandom_range(0, 20'hFFFFF));
            bv = 64'($urandom_range(0, 18'h3FFFF));
            sv = 64'($urandom_range(0, 63));
            a = a_t'(av); b = b_t'(bv); acc_fir = sh_t'(sv);
            exp_arr[i] = model(av, bv, int'(sv));
            tick(1);
            if (i >= LAT - 1)
                check("random", 64'(z_out), exp_arr[i-LAT+1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_dsp_shifted_a_mult_add

// File: doc/dsp_shifted_a_mult_add.md
Name: dsp_shifted_a_mult_add

Overview:
- DSP-slice arithmetic stage that computes z = (a << acc_fir) + (b × MULT_CONST). MULT_CONST defaults to 4096, a constant multiplier equivalent to b << 12.
- The result is modulo 2^Z_WIDTH and is registered once on the output.
- Sits in the FIR/MAC datapath, where the per-sample shift on a comes from the accumulator/FIR shift control.

Parameters:
- A_WIDTH, 20, width of operand a (unsigned)
- B_WIDTH, 18, width of operand b (unsigned)
- SHIFT_WIDTH, 6, width of shift amount acc_fir
- Z_WIDTH, 38, width of result z_out
- MULT_CONST, 4096, constant multiplier applied to b (unsigned, at most 2^20)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable for all pipeline registers
- a  in  A_WIDTH  unsigned operand, left-shifted by acc_fir
- b  in  B_WIDTH  unsigned operand, multiplied by MULT_CONST
- acc_fir  in  SHIFT_WIDTH  unsigned left-shift amount, 0..63
- z_out  out  Z_WIDTH  registered result

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Arithmetic:
  - All operands are unsigned; there is no sign extension anywhere.
  - sh = (zero-extend a to Z_WIDTH) << acc_fir. Bits shifted beyond Z_WIDTH-1 are discarded.
  - Any acc_fir ≥ Z_WIDTH (38..63) gives sh = 0.
  - p = b × MULT_CONST, computed at full width, then truncated to Z_WIDTH.
  - z_next = (sh + p) mod 2^Z_WIDTH. Carry out of the MSB is dropped (wrap-around, no saturation).
- Timing:
  - z_out <= z_next on each rising clk edge where en = 1. Latency is 1 cycle from input sample to z_out.
  - When en = 0, z_out holds its value.
  - No handshake; a new input set is accepted every enabled cycle.
- Reset:
  - rst_n low forces z_out = 0 immediately (asynchronous assert) and keeps it 0 while low.
  - Release is synchronous to the next clk edge; the first enabled edge after release loads z_next.
  - Asserting reset mid-stream discards any in-flight value.
- X-handling: no X on z_out after reset for any defined inputs.

Optional Feature:
- Macro: DSP_INPUT_REG_EN.
- When defined: a, b and acc_fir are registered (reset to 0, gated by en) before the arithmetic. Total latency is 2 cycles, and z_out after reset release is 0 until valid data has propagated.
- When undefined: inputs feed the arithmetic combinationally, with 1-cycle latency as above.
- The arithmetic result is identical in both builds.

Decomposition:
- Package dsp_madd_pkg holds:
  - default width localparams: A_W = 20, B_W = 18, SH_W = 6, Z_W = 38
  - default MULT_CONST = 4096
  - typedefs for the operand and result vectors
- Natural sub-module: dsp_barrel_shl, a parametric logarithmic left shifter (Z_WIDTH data, SHIFT_WIDTH amount) that zero-fills and returns 0 for out-of-range shifts.
- Multiply-by-constant and add stay in the top level.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> z_out = 0. Release, apply a = 255, b = 1, acc_fir = 1 -> one enabled cycle later z_out = 4606 (510 + 4096).
- Max shift / out-of-range shift: a = 0xFFFFF, b = 0x3FFFF, acc_fir = 63 -> z_out = 1073737728 (shifted term 0, p = 0x3FFFF000).
- Shift truncation: a = 0xFFFFF, b = 0, acc_fir = 19 -> z_out = 274877382656 (top bit of a discarded); acc_fir = 18 -> 274877644800.
- Sum wrap-around: a = 0xFFFFF, acc_fir = 18, b = 0x40 -> sum 0x4000000000, so z_out = 0.
- Enable hold: load a = 255, b = 1, acc_fir = 1, then set en = 0 and change inputs -> z_out stays 4606 until en returns to 1.
- Random regression: 1000 random a, b, acc_fir with en = 1 -> z_out equals ((a << acc_fir) + 4096·b) mod 2^38, delayed by 1 cycle (2 cycles with DSP_INPUT_REG_EN defined).
